// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings for the EX forwarding muxes and the shadow-pipeline result types.
package fwd_hazard_ctrl_pkg;

  localparam logic [2:0] FWD_RF      = 3'd0;
  localparam logic [2:0] FWD_IMM_MEM = 3'd1;
  localparam logic [2:0] FWD_ALU_MEM = 3'd2;
  localparam logic [2:0] FWD_IMM_WB  = 3'd3;
  localparam logic [2:0] FWD_ALU_WB  = 3'd4;
  localparam logic [2:0] FWD_MEM_WB  = 3'd5;

  typedef enum logic [1:0] {
    RT_NONE = 2'd0,
    RT_ALU  = 2'd1,
    RT_IMM  = 2'd2,
    RT_LOAD = 2'd3
  } rtype_e;

  // The MEM-bound (younger) producer shadows the WB-bound one. A load still in
  // EX is never forwarded: the interlock keeps its consumer out of EX.
  function automatic logic [2:0] fwd_code(input logic   ex_hit,
                                          input rtype_e ex_rt,
                                          input logic   mem_hit,
                                          input rtype_e mem_rt);
    logic [2:0] code;
    code = FWD_RF;
    if (ex_hit) begin
      case (ex_rt)
        RT_ALU:  code = FWD_ALU_MEM;
        RT_IMM:  code = FWD_IMM_MEM;
        default: code = FWD_RF;
      endcase
    end else if (mem_hit) begin
      case (mem_rt)
        RT_ALU:  code = FWD_ALU_WB;
        RT_IMM:  code = FWD_IMM_WB;
        RT_LOAD: code = FWD_MEM_WB;
        default: code = FWD_RF;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Per-operand forward-select: compares one ID source against the EX and MEM shadows.
module fwd_hazard_ctrl_fwd_sel
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NREGS_ZERO = 0
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              ex_valid,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_dst,
  input  rtype_e            ex_rtype,
  input  logic              mem_valid,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_dst,
  input  rtype_e            mem_rtype,
  output logic [2:0]        code
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;

  assign src_live = use_src && (src != REG_AW'(NREGS_ZERO));
  assign ex_hit   = src_live && ex_valid && ex_wr && (ex_rtype != RT_NONE) && (ex_dst == src);
  assign mem_hit  = src_live && mem_valid && mem_wr && (mem_rtype != RT_NONE) && (mem_dst == src);
  assign code     = fwd_code(ex_hit, ex_rtype, mem_hit, mem_rtype);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding and load-use interlock with a private EX/MEM/WB shadow pipeline.
// Optional build macro FWD_PERF_EN adds stall and forward event counters.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NREGS_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr,
  input  logic [1:0]        id_rtype,
  output logic              stall,
  output logic [2:0]        ALUa_Fwd_ctr,
  output logic [2:0]        ALUb_Fwd_ctr
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] dst;
    rtype_e            rtype;
  } shadow_t;

  shadow_t    ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
  logic [2:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  logic [2:0] code_a, code_b;
  logic       dep_rs, dep_rt;

  fwd_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW), .NREGS_ZERO(NREGS_ZERO)) u_sel_a (
    .src(id_rs), .use_src(id_use_rs),
    .ex_valid(ex_q.valid), .ex_wr(ex_q.wr), .ex_dst(ex_q.dst), .ex_rtype(ex_q.rtype),
    .mem_valid(mem_q.valid), .mem_wr(mem_q.wr), .mem_dst(mem_q.dst), .mem_rtype(mem_q.rtype),
    .code(code_a)
  );

  fwd_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW), .NREGS_ZERO(NREGS_ZERO)) u_sel_b (
    .src(id_rt), .use_src(id_use_rt),
    .ex_valid(ex_q.valid), .ex_wr(ex_q.wr), .ex_dst(ex_q.dst), .ex_rtype(ex_q.rtype),
    .mem_valid(mem_q.valid), .mem_wr(mem_q.wr), .mem_dst(mem_q.dst), .mem_rtype(mem_q.rtype),
    .code(code_b)
  );

  assign dep_rs = id_use_rs && (id_rs == ex_q.dst);
  assign dep_rt = id_use_rt && (id_rt == ex_q.dst);
  assign stall  = id_valid && ex_q.valid && ex_q.wr && (ex_q.rtype == RT_LOAD) &&
                  (ex_q.dst != REG_AW'(NREGS_ZERO)) && (dep_rs || dep_rt);

  // NOTE: every always_comb output takes a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!hold) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (stall || flush) begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end else begin
        ex_d.valid = id_valid;
        ex_d.wr    = id_wr;
        ex_d.dst   = id_dst;
        ex_d.rtype = rtype_e'(id_rtype);
        fwd_a_d    = id_valid ? code_a : FWD_RF;
        fwd_b_d    = id_valid ? code_b : FWD_RF;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ALUa_Fwd_ctr = fwd_a_q;
  assign ALUb_Fwd_ctr = fwd_b_q;

`ifdef FWD_PERF_EN
  logic [31:0] perf_stall_d, perf_stall_q, perf_fwd_d, perf_fwd_q;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_fwd_d   = perf_fwd_q;
    if (!hold) begin
      if (stall) perf_stall_d = perf_stall_q + 32'd1;
      if ((fwd_a_d != FWD_RF) || (fwd_b_d != FWD_RF)) perf_fwd_d = perf_fwd_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q   <= perf_fwd_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl: forwarding codes, load-use stall, flush, hold, reset.
module tb_fwd_hazard_ctrl;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_ALU  = 2'd1;
  localparam logic [1:0] T_IMM  = 2'd2;
  localparam logic [1:0] T_LOAD = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_dst;
  logic       id_wr;
  logic [1:0] id_rtype;
  logic       stall;
  logic [2:0] ALUa_Fwd_ctr;
  logic [2:0] ALUb_Fwd_ctr;
`ifdef FWD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dst(id_dst), .id_wr(id_wr), .id_rtype(id_rtype),
    .stall(stall), .ALUa_Fwd_ctr(ALUa_Fwd_ctr), .ALUb_Fwd_ctr(ALUb_Fwd_ctr)
`ifdef FWD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic wr, input logic [1:0] rtype);
    id_valid  = v;
    id_rs     = rs;
    id_rt     = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    id_dst    = dst;
    id_wr     = wr;
    id_rtype  = rtype;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_codes(input string tag, input logic [2:0] a, input logic [2:0] b);
    check({tag, "_a"}, 32'(ALUa_Fwd_ctr), 32'(a));
    check({tag, "_b"}, 32'(ALUb_Fwd_ctr), 32'(b));
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, T_NONE);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check_codes("reset", 3'd0, 3'd0);
    #10 rst_n = 1'b1;

    // add $3,$1,$2 then add $4,$3,$5: EX-stage ALU producer -> code 2, no stall
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, T_ALU);
    check("add3_stall", 32'(stall), 32'd0);
    step();
    check_codes("add3", 3'd0, 3'd0);
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, T_ALU);
    check("add4_stall", 32'(stall), 32'd0);
    step();
    check_codes("add4", 3'd2, 3'd0);

    // lui $3; add $9; or $6,$0,$3 -> ExtImm from WB on B
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, T_IMM);
    step();
    drive(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd9, 1'b1, T_ALU);
    step();
    drive(1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, T_ALU);
    step();
    check_codes("or6", 3'd0, 3'd3);

    // lw $2 then add $7,$2,$2: one bubble, then MemRd_WB on both
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, T_LOAD);
    step();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, T_ALU);
    check("lu_stall_on", 32'(stall), 32'd1);
    step();
    check_codes("lu_bubble", 3'd0, 3'd0);
    check("lu_stall_off", 32'(stall), 32'd0);
    step();
    check_codes("lu_dep", 3'd5, 3'd5);

    // lw $8; add $8; use $8 -> MEM-bound ALU wins over WB-bound load
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, T_LOAD);
    step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, T_ALU);
    check("add8_stall", 32'(stall), 32'd0);
    step();
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, T_ALU);
    check("prio_stall", 32'(stall), 32'd0);
    step();
    check_codes("prio", 3'd2, 3'd0);

    // Register $0 is never forwarded and never interlocks
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, T_ALU);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, T_ALU);
    step();
    check_codes("zero_alu", 3'd0, 3'd0);
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, T_LOAD);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, T_ALU);
    check("zero_load_stall", 32'(stall), 32'd0);
    step();

    // Load-use with flush in the same cycle: bubble, then the new ID instr gets MemRd_WB
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, T_LOAD);
    step();
    drive(1'b1, 5'd12, 5'd3, 1'b1, 1'b1, 5'd20, 1'b1, T_ALU);
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b0;
    check_codes("flush_bubble", 3'd0, 3'd0);
    drive(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd21, 1'b1, T_ALU);
    check("post_flush_stall", 32'(stall), 32'd0);
    step();
    check_codes("post_flush", 3'd5, 3'd5);

    // hold for 3 cycles (one with flush): everything freezes
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, T_ALU);
    step();
    drive(1'b1, 5'd13, 5'd0, 1'b1, 1'b1, 5'd14, 1'b1, T_ALU);
    step();
    check_codes("pre_hold", 3'd2, 3'd0);
    hold = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd22, 1'b1, T_ALU);
    step();
    check_codes("hold1", 3'd2, 3'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_codes("hold2", 3'd2, 3'd0);
    step();
    check_codes("hold3", 3'd2, 3'd0);
    hold = 1'b0;
    drive(1'b1, 5'd14, 5'd13, 1'b1, 1'b1, 5'd15, 1'b1, T_LOAD);
    step();
    check_codes("resume", 3'd2, 3'd4);

    // Asynchronous reset mid-cycle while a load-use stall is pending
    drive(1'b1, 5'd15, 5'd1, 1'b1, 1'b1, 5'd23, 1'b1, T_ALU);
    check("prerst_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check_codes("rst", 3'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_stall", 32'(stall), 32'd0);
    step();
    check_codes("postrst", 3'd0, 3'd0);
`ifdef FWD_PERF_EN
    check("perf_stall0", perf_stall_cnt, 32'd0);
    check("perf_fwd0", perf_fwd_cnt, 32'd0);
`endif

    // One more load-use after reset
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, T_LOAD);
    step();
    drive(1'b1, 5'd16, 5'd0, 1'b1, 1'b0, 5'd24, 1'b1, T_ALU);
    check("lu2_stall", 32'(stall), 32'd1);
    step();
`ifdef FWD_PERF_EN
    check("perf_stall1", perf_stall_cnt, 32'd1);
    check("perf_fwd_still0", perf_fwd_cnt, 32'd0);
`endif
    step();
    check_codes("lu2_dep", 3'd5, 3'd0);
`ifdef FWD_PERF_EN
    check("perf_fwd1", perf_fwd_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequences the EX-stage operand forwarding muxes and the pipeline interlocks for the 5-stage core.
- Keeps its own shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Emits registered 3-bit forward selects for ALU operands A and B, and a load-use stall/bubble.
- Sits beside the ID/EX pipeline register; all outputs drive the ID/EX boundary and the EX stage.

Parameters:
REG_AW, 5, register-address width
NREGS_ZERO, 0, hard-wired zero register index; never forwarded

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
hold  in  1  external freeze (memory busy); all internal state holds
flush  in  1  branch/jump taken; squash the instruction in ID
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  source A register
id_rt  in  REG_AW  source B register
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_dst  in  REG_AW  destination register
id_wr  in  1  instruction writes id_dst
id_rtype  in  2  result source: 0 none, 1 ALU, 2 ExtImm (lui-type), 3 load
stall  out  1  hold PC and IF/ID; insert bubble into EX
ALUa_Fwd_ctr  out  3  EX operand A select
ALUb_Fwd_ctr  out  3  EX operand B select

Behaviour:
- Forward-select encoding, fixed for the EX mux:
  - 0 regfile
  - 1 ExtImm_MEM
  - 2 ALUres_MEM
  - 3 ExtImm_WB
  - 4 ALUres_WB
  - 5 MemRd_WB
  - 6, 7 never produced.
- Shadow registers ex_*, mem_*, wb_*: {valid, wr, dst, rtype}. Each advances one stage per clk when hold=0.
- Reset (rst_n=0, asynchronous): all shadow valid=0, ALUa/ALUb_Fwd_ctr=0, stall=0.
- stall is combinational from ID inputs and ex_* state. stall=1 iff all of the following hold:
  - id_valid=1
  - ex_valid=1, ex_wr=1, ex_rtype=3
  - ex_dst≠0
  - (id_use_rs and id_rs==ex_dst) or (id_use_rt and id_rt==ex_dst)
- Forward codes are computed at the ID→EX edge, so the outputs are registered and valid for the whole EX cycle. For operand A (B identical with rt):
  - If the ex_* producer matches (it will be in MEM next cycle): rtype1→2, rtype2→1. rtype3 cannot occur because stall prevents it.
  - Else if the mem_* producer matches (it will be in WB): rtype1→4, rtype2→3, rtype3→5.
  - Else 0.
- Match condition: valid & wr & dst==src & use_src & src≠0. The younger (MEM-bound) producer has priority over WB.
- Next EX entry:
  - stall=1 or flush=1: bubble. ex_valid←0, Fwd_ctr←0.
  - Otherwise: ex_*←id_*, valid←id_valid.
- MEM←EX and WB←MEM always advance when hold=0, including during stall.
- hold=1: every register keeps its value; stall is still computed but has no effect until hold drops.
- Simultaneous events:
  - flush and stall together: flush wins (bubble; the IF/ID squash is done by the fetch logic).
  - hold with flush: the flush is ignored that cycle. The fetch logic re-asserts it.
- id_rtype=0 or id_wr=0: the instruction is never a forwarding source.
- Reset mid-operation: immediate clear; the first post-reset instruction sees Fwd_ctr=0.
- Latency: stall resolves a load-use in exactly 1 bubble. Back-to-back dependents need 0 bubbles for ALU/ExtImm producers.

Optional Feature:
- Macro: FWD_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_fwd_cnt[31:0].
  - perf_stall_cnt increments each non-hold cycle with stall=1.
  - perf_fwd_cnt increments each non-hold cycle where a nonzero code is loaded into either Fwd_ctr. It increments once even if both operands forward.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - forward-select localparams FWD_RF=0, FWD_IMM_MEM=1, FWD_ALU_MEM=2, FWD_IMM_WB=3, FWD_ALU_WB=4, FWD_MEM_WB=5
  - result-type codes RT_NONE, RT_ALU, RT_IMM, RT_LOAD
- One natural sub-module: fwd_sel. It is a combinational per-operand select given src, use, and the ex/mem shadows. It is instantiated twice (A, B).

Test Plan:
- add $3 then add $4,$3,$5 back-to-back → ALUa_Fwd_ctr=2 in the dependent's EX cycle, stall never 1.
- lui $3 then one independent instr then or $6,$0,$3 → ALUb_Fwd_ctr=3, ALUa_Fwd_ctr=0.
- lw $2 then add $7,$2,$2 → stall=1 for exactly 1 cycle. The dependent then enters EX with both codes=5.
- add $8 and lw $8 in flight, then use $8 → code 2 (MEM priority over WB); write to $0 then read $0 → code 0.
- load-use stall with flush=1 in the same cycle → bubble into EX, codes 0. hold=1 for 3 cycles mid-sequence → outputs frozen, resume unchanged.
- rst_n low mid-stream → codes 0 and stall 0 asynchronously. With FWD_PERF_EN, the counters read 0 and then count 1 stall per load-use.
